// File: rtl/uart_pkg.sv
// Shared UART constants and transmit FSM encoding.
// Used by the transmit scheduler and the baud generator shared with the receive side.
`timescale 1ns/1ps
package uart_pkg;

    localparam int   DATA_W   = 8;
    localparam logic STARTBIT = 1'b0;
    localparam logic STOPBIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// A clear restarts the period so the next bit is full width.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int CLK_DIV = 434,
    parameter int CTR_W   = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [CTR_W-1:0] cnt;

    assign tick = (cnt == CTR_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding N_REQ byte producers into one UART transmitter.
// Frame: start bit, 8 data bits MSB first, stop bit; one IDLE cycle between frames.
`timescale 1ns/1ps
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CLK_DIV = 434,
    parameter int CTR_W   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [8*N_REQ-1:0]      req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    txd,
    output logic                    busy,
    output logic [2:0]              grant_id,
    output logic                    done
);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] win_byte;
    logic [2:0]        bit_ctr;
    logic [2:0]        rr_ptr;
    logic [2:0]        win;
    logic              found;
    logic              tick;
    logic              baud_clr;
    logic              accept;

    // First valid index at or after ptr, wrapping; returns {hit, index}.
    function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] v, input logic [2:0] ptr);
        logic       hit;
        logic [2:0] idx;
        int         j;
        hit = 1'b0;
        idx = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!hit && v[j]) begin
                hit = 1'b1;
                idx = 3'(j);
            end
        end
        return {hit, idx};
    endfunction

    always_comb begin
        {found, win} = rr_pick(req_valid, rr_ptr);
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == win) win_byte = req_data[8*i +: 8];
        end
    end

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV),
        .CTR_W   (CTR_W)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        baud_clr  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Counter held clear while idle so the start bit is a full period.
                baud_clr = 1'b1;
                if (found) begin
                    accept    = 1'b1;
                    req_ready = N_REQ'(1) << win;
                    state_nxt = START;
                end
            end
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_ctr == 3'd7) state_nxt = STOP;
            STOP:  if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == STOP) && tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_ctr   <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
        end else if (accept) begin
            shift_reg <= win_byte;
            bit_ctr   <= '0;
            grant_id  <= win;
            rr_ptr    <= 3'((int'(win) + 1) % N_REQ);
        end else if (state == DATA && tick) begin
            shift_reg <= shift_reg << 1;
            bit_ctr   <= bit_ctr + 3'd1;
        end
    end

    // txd is driven from the next state so the line changes on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd <= STOPBIT;
        end else begin
            case (state_nxt)
                START:   txd <= STARTBIT;
                DATA:    txd <= (state == DATA && tick) ? shift_reg[DATA_W-2] : shift_reg[DATA_W-1];
                default: txd <= STOPBIT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched at CLK_DIV=4, N_REQ=4: a serial monitor
// decodes each frame and compares it to the expected {grant, byte} queue.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int N_REQ   = 4;
    localparam int CLK_DIV = 4;
    localparam int TMO     = 1000;

    typedef struct packed {
        logic [2:0] gid;
        logic [7:0] data;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               txd;
    logic               busy;
    logic [2:0]         grant_id;
    logic               done;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   frames = 0;
    logic mon_en;
    exp_t exp_q[$];
    int   f_start[$];
    int   f_idle[$];
    int   f_done[$];
    int   rdy_cnt[N_REQ];
    int   exp_rdy[N_REQ];

    uart_tx_sched #(.N_REQ(N_REQ), .CLK_DIV(CLK_DIV), .CTR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.gid  = 3'(id);
        e.data = d;
        exp_q.push_back(e);
        exp_rdy[id]++;
    endtask

    task automatic wait_rdy(input int id, output int acc);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[id] && t < TMO);
        chk($sformatf("rdy_seen_%0d", id), 32'(req_ready[id]), 1);
        acc = cyc;
    endtask

    task automatic drop_after(input int id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("frames_done", 32'(frames >= n), 1);
    endtask

    // Handshake monitor: ready is one-hot and only offered to a valid requester.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            chk("rdy_onehot", 32'($onehot(req_ready)), 1);
            chk("rdy_valid", 32'((req_ready & ~req_valid) == '0), 1);
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
        end
    end

    // Serial monitor: decodes frames by bit position, checks shape and scoreboard.
    initial begin
        int         idle_run;
        logic [2:0] gid;
        logic [7:0] byte_v;
        logic       b;
        logic       ok;
        exp_t       e;
        idle_run = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                idle_run = 0;
            end else if (txd) begin
                idle_run++;
            end else begin
                f_start.push_back(cyc);
                f_idle.push_back(idle_run);
                idle_run = 0;
                gid = grant_id;
                ok  = 1'b1;
                for (int k = 0; k < CLK_DIV; k++) begin
                    if (k > 0) @(negedge clk);
                    if (txd !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || grant_id !== gid) ok = 1'b0;
                end
                byte_v = '0;
                for (int bi = 0; bi < 8; bi++) begin
                    b = 1'b0;
                    for (int k = 0; k < CLK_DIV; k++) begin
                        @(negedge clk);
                        if (k == 0) b = txd;
                        else if (txd !== b) ok = 1'b0;
                        if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
                    end
                    byte_v = {byte_v[6:0], b};
                end
                for (int k = 0; k < CLK_DIV; k++) begin
                    @(negedge clk);
                    if (txd !== 1'b1 || busy !== 1'b1) ok = 1'b0;
                    if (done !== (k == CLK_DIV - 1)) ok = 1'b0;
                    if (done === 1'b1) f_done.push_back(cyc);
                end
                chk("frame_shape", 32'(ok), 1);
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("frame_gid", 32'(gid), 32'(e.gid));
                    chk("frame_byte", 32'(byte_v), 32'(e.data));
                end
                frames++;
            end
        end
    end

    initial begin
        int a;
        int base;
        int r3;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        mon_en    = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            rdy_cnt[i] = 0;
            exp_rdy[i] = 0;
        end
        #12;
        chk("rst_txd", 32'(txd), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_gid", 32'(grant_id), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // All four valid: strict round robin 0..3 with one idle cycle between frames.
        base = frames;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) push(i, req_data[8*i +: 8]);
        for (int i = 0; i < 4; i++) begin
            wait_rdy(i, a);
            drop_after(i);
        end
        wait_frames(base + 4);
        for (int k = 1; k < 4; k++) begin
            chk("t2_idle_gap", 32'(f_idle[base+k]), 1);
            chk("t2_spacing", 32'(f_start[base+k] - f_start[base+k-1]), 32'(10*CLK_DIV + 1));
        end
        chk("t2_gid_hold", 32'(grant_id), 3);

        // Single request: latency to start bit and to done.
        base = frames;
        req_data[7:0] = 8'hA5;
        req_valid[0]  = 1'b1;
        push(0, 8'hA5);
        wait_rdy(0, a);
        drop_after(0);
        wait_frames(base + 1);
        chk("t1_start_lat", 32'(f_start[base]), 32'(a + 1));
        chk("t1_done_lat", 32'(f_done[base]), 32'(a + 10*CLK_DIV));

        // valid[2] held while valid[1] rises mid-frame; pointer then sits at 3.
        base = frames;
        req_valid[2] = 1'b1;
        push(2, 8'h33);
        wait_rdy(2, a);
        repeat (10) @(posedge clk);
        #1;
        req_data[15:8] = 8'h5A;
        req_valid[1]   = 1'b1;
        push(1, 8'h5A);
        push(2, 8'h33);
        wait_rdy(1, a);
        drop_after(1);
        wait_rdy(2, a);
        drop_after(2);
        wait_frames(base + 3);
        chk("t3_gid_hold", 32'(grant_id), 2);

        // Reset during data bit 3 (byte E1: bit 3 is low on the line).
        mon_en = 1'b0;
        req_data[7:0] = 8'hE1;
        req_valid[0]  = 1'b1;
        exp_rdy[0]++;
        wait_rdy(0, a);
        drop_after(0);
        repeat (17) @(posedge clk);
        #2;
        chk("t4_pre_txd", 32'(txd), 0);
        chk("t4_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_txd", 32'(txd), 1);
        chk("t4_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_gid", 32'(grant_id), 0);
        mon_en = 1'b1;
        base = frames;
        @(posedge clk);
        #1;
        req_data[15:0] = 16'hC33C;
        req_valid[1:0] = 2'b11;
        push(0, 8'h3C);
        push(1, 8'hC3);
        wait_rdy(0, a);
        drop_after(0);
        wait_rdy(1, a);
        drop_after(1);
        wait_frames(base + 2);

        // valid[3] pulsed for one cycle while busy must be ignored.
        base = frames;
        r3   = rdy_cnt[3];
        req_data[7:0] = 8'h96;
        req_valid[0]  = 1'b1;
        push(0, 8'h96);
        wait_rdy(0, a);
        drop_after(0);
        repeat (5) @(posedge clk);
        #1;
        req_data[31:24] = 8'h77;
        req_valid[3]    = 1'b1;
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_frames(base + 1);
        repeat (10) @(posedge clk);
        chk("t5_no_rdy3", 32'(rdy_cnt[3]), 32'(r3));
        chk("t5_no_frame", 32'(frames), 32'(base + 1));

        // 00 then FF back to back: start/stop widths and a 5-cycle high gap.
        base = frames;
        #1;
        req_data[23:8] = 16'hFF00;
        req_valid[2:1] = 2'b11;
        push(1, 8'h00);
        push(2, 8'hFF);
        wait_rdy(1, a);
        drop_after(1);
        wait_rdy(2, a);
        drop_after(2);
        wait_frames(base + 2);
        chk("t6_idle_gap", 32'(f_idle[base+1]), 1);
        chk("t6_spacing", 32'(f_start[base+1] - f_start[base]), 32'(10*CLK_DIV + 1));

        chk("sb_empty", 32'(exp_q.size()), 0);
        for (int i = 0; i < N_REQ; i++) chk($sformatf("rdy_total_%0d", i), 32'(rdy_cnt[i]), 32'(exp_rdy[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
